mult_seq_accum: RTL

- Sequential control and accumulate stage of the iterative 32x32 MIPS multiplier.
- Drives the 5-bit partial-product select into the 32:1 64-bit partial-product mux.
- Sums the selected 64-bit partial product into a running product, one per cycle.
- Presents the 64-bit result as HI/LO to the datapath with a start/busy/done handshake.

---
 rtl/mult_seq_accum_pkg.sv | 29 ++
 rtl/mult_seq_accum_if.sv | 32 +++
 rtl/mult_seq_accum.sv | 109 ++++++++++
 3 files changed

// File: rtl/mult_seq_accum_pkg.sv
// Package for the sequential multiplier accumulate stage.
// Holds the operand/product widths, the cycle count, the control state
// encoding and the helper that builds the early-termination mask.
// Used by: mult_seq_accum_if, mult_seq_accum.
package mult_pkg;

  localparam int MULT_CYCLES = 32;                 // partial products per op
  localparam int SEL_W       = $clog2(MULT_CYCLES); // mux select width
  localparam int OP_W        = 32;                 // operand width
  localparam int PROD_W      = 64;                 // product width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mult_state_t;

  // Mask of multiplier bit positions strictly above the given select.
  // ANDed with the latched multiplier, an all-zero result means no later
  // partial product can contribute, so accumulation may stop early.
  function automatic logic [OP_W-1:0] above_mask(input logic [SEL_W-1:0] s);
    logic [OP_W-1:0] m;
    for (int i = 0; i < OP_W; i++) begin
      m[i] = (i > int'(s));
    end
    return m;
  endfunction

endpackage

// File: rtl/mult_seq_accum_if.sv
// Handshake and data bundle between the datapath/partial-product mux and
// the multiplier accumulate stage.
//   start, is_signed, mplier : request and operand controls (datapath side)
//   pp_in                    : partial product from the mux for current sel
//   sel                      : partial-product select into the mux
//   busy, done               : accumulate in progress / one-cycle completion
//   hi, lo                   : product[63:32] / product[31:0]
// Modports: master = datapath/mux side, slave = accumulate stage.
interface mult_seq_accum_if;
  import mult_pkg::*;

  logic              start;
  logic              is_signed;
  logic [OP_W-1:0]   mplier;
  logic [PROD_W-1:0] pp_in;
  logic [SEL_W-1:0]  sel;
  logic              busy;
  logic              done;
  logic [OP_W-1:0]   hi;
  logic [OP_W-1:0]   lo;

  modport master (
    output start, is_signed, mplier, pp_in,
    input  sel, busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, mplier, pp_in,
    output sel, busy, done, hi, lo
  );

endinterface

// File: rtl/mult_seq_accum.sv
// Sequential control and accumulate stage of the iterative 32x32 multiplier.
// Steps the partial-product select 0..31, adds each returned 64-bit partial
// product into a running product (subtracting the sel==31 term for signed
// operations so the multiplier sign bit carries weight -2^31), then pulses
// done for one cycle. hi/lo hold the product until the next accepted start.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : mult_seq_accum_if.slave (start/is_signed/mplier/pp_in in,
//           sel/busy/done/hi/lo out)
// Optional feature macro: MULT_EARLY_TERM_EN -- when defined, accumulation
// stops as soon as no higher multiplier bit is set.
module mult_seq_accum
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mult_seq_accum_if.slave  bus
);

  mult_state_t       state_reg, state_next;
  logic [SEL_W-1:0]  sel_reg;
  logic [PROD_W-1:0] acc_reg;
  logic              signed_reg;

  logic              last_step;
  logic              subtract;
  logic              early_exit;
  logic [PROD_W-1:0] acc_next;

  assign last_step = (sel_reg == SEL_W'(MULT_CYCLES - 1));
  // Only the sign-bit partial product of a signed multiply is subtracted.
  assign subtract  = signed_reg && last_step;
  assign acc_next  = subtract ? (acc_reg - bus.pp_in) : (acc_reg + bus.pp_in);

`ifdef MULT_EARLY_TERM_EN
  logic [OP_W-1:0] mplier_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mplier_reg <= '0;
    end else if (state_reg == IDLE && bus.start) begin
      mplier_reg <= bus.mplier;
    end
  end

  // The signed sign-bit step is excluded; it is the final step anyway.
  assign early_exit = ((mplier_reg & above_mask(sel_reg)) == '0) && !subtract;
`else
  logic unused_mplier;
  assign unused_mplier = ^bus.mplier;
  assign early_exit    = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = RUN;
      RUN:  if (last_step || early_exit) state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: select counter, accumulator and latched signedness.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_reg    <= '0;
      acc_reg    <= '0;
      signed_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sel_reg    <= '0;
            acc_reg    <= '0;
            signed_reg <= bus.is_signed;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          // sel returns to 0 when leaving RUN, so IDLE always presents 0.
          if (state_next == FIN) begin
            sel_reg <= '0;
          end else begin
            sel_reg <= sel_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sel  = sel_reg;
  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == FIN);
  assign bus.hi   = acc_reg[PROD_W-1:OP_W];
  assign bus.lo   = acc_reg[OP_W-1:0];

endmodule
